fp_exe_sched: RTL and testbench
===============================

// Module: fp_exe_sched
// PURPOSE
//  In-order FP execute scheduler that succeeds the combinational FP execute stage: accepts one op
//  per cycle, dispatches it to a short path (cmp/sgnj/max/class/mv/cvt, result supplied with the
//  request), the fixed-latency pipelined FMA unit, or the iterative FDIV/FSQRT unit.
//  Holds results in a DEPTH-entry completion queue, so several ops may be in flight.
//  Retires results strictly in issue order through a valid/ready response port.
// PARAMETERS
//  XLEN     64  result/data width
//  DEPTH    4   completion-queue entries (power of 2, >=2); max ops in flight
//  FMA_LAT  3   FMA issue-to-result latency in cycles (>=1)
//  TAG_W    4   width of caller-supplied op tag
// PORTS
//  clock          in   1      rising-edge clock
//  reset          in   1      asynchronous, active-high reset
//  clear          in   1      synchronous flush of all in-flight ops (pipeline kill)
//  req_valid      in   1      op offered
//  req_ready      out  1      op accepted when req_valid & req_ready
//  req_kind       in   2      0=short, 1=fma, 2=div/sqrt, 3=reserved (treated as short)
//  req_tag        in   TAG_W  returned unchanged with the result
//  req_result     in   XLEN   short-path result (used only for kind 0/3)
//  req_flags      in   5      short-path fflags {NV,DZ,OF,UF,NX}
//  fma_issue      out  1      pulse: FMA operands valid this cycle
//  fma_result     in   XLEN   FMA rounded result, valid FMA_LAT cycles after fma_issue
//  fma_flags      in   5      FMA fflags, same timing
//  div_start      out  1      pulse: start FDIV/FSQRT
//  div_done       in   1      pulse: divider result valid
//  div_result     in   XLEN   divider result
//  div_flags      in   5      divider fflags
//  rsp_valid      out  1      head entry complete
//  rsp_ready      in   1      consumer takes head when rsp_valid & rsp_ready
//  rsp_result     out  XLEN   head result
//  rsp_flags      out  5      head fflags
//  rsp_tag        out  TAG_W  head tag
//  busy           out  1      any queue entry allocated or divider running
// BEHAVIOUR
//  Reset/clear: queue empty, wr/rd pointers 0, FMA slot pipe invalid, div FSM IDLE; rsp_valid=0,
//   fma_issue=0, div_start=0, busy=0, rsp_result/flags/tag=0. Clear acts even if req/rsp fire same cycle
//   (no accept, no retire); div_done arriving after clear is ignored.
//  Queue: circular, ptr width log2(DEPTH)+1 (extra wrap bit); full when low bits equal, wrap bits differ.
//   Entry = {alloc, done, tag, result, flags}. Allocate at tail on accept, in issue order.
//  req_ready = !full & !clear & !(req_kind==2 & div_state!=IDLE). Combinational, not dependent on req_valid.
//  Short op: entry written alloc=1, done=1 at accept edge; earliest rsp_valid next cycle (latency 1).
//  FMA op: fma_issue=req_valid&req_ready&kind==1 (combinational); slot index shifted through an
//   FMA_LAT-deep valid/index pipe; at the output stage result+flags written, done=1. Back-to-back FMA
//   issue each cycle allowed. Latency to rsp_valid = FMA_LAT+1.
//  Div FSM: IDLE -(accept kind 2)-> RUN (div_start pulse on accept cycle, slot index latched)
//   -(div_done)-> IDLE with result written, done=1. Only one div in flight; div_done in IDLE ignored.
//  Retire: rsp_valid = head.alloc & head.done; outputs driven from head entry (combinational read).
//   On rsp_valid&rsp_ready: free head, rd_ptr++ (wraps). Younger completed ops wait behind older.
//  Simultaneous accept+retire when full: not accepted (req_ready=0 while full, no bypass).
//  Simultaneous accept+retire when empty: short op not visible until next cycle (no bypass).
//  Two writebacks same cycle (FMA output + div_done + new short op) target distinct slots; all land.
//  busy = !empty | (div_state==RUN).
// TESTING
//  Reset mid-flight: 2 FMAs queued, assert reset -> rsp_valid=0, busy=0, req_ready=1 same cycle.
//  3 short ops back-to-back, rsp_ready=1 -> tags 1,2,3 on consecutive cycles from cycle 1; flags passed.
//  div(tag 5, done after 10 cyc) then short(tag 6) -> tag 6 held until tag 5 retires; order 5,6.
//  FMA_LAT=3, FMA tag 7 then short tag 8 -> 8 complete at cycle 1 but rsp order 7 (cycle 4), 8 (cycle 5).
//  Fill DEPTH=4 with rsp_ready=0 -> req_ready=0 at 4th accept+1; release one -> req_ready=1 next cycle.
//  Second div while RUN -> req_ready=0; clear during RUN then late div_done -> no response, queue empty.

Source files
------------

// File: rtl/fp_exe_sched_if.sv
// Request/response bundle between the FP execute stage and its in-order result scheduler.
// The master side offers ops and consumes results; the slave side is the scheduler.
interface fp_exe_sched_if #(
  parameter int XLEN  = 64,
  parameter int TAG_W = 4
);
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_kind;
  logic [TAG_W-1:0] req_tag;
  logic [XLEN-1:0]  req_result;
  logic [4:0]       req_flags;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [XLEN-1:0]  rsp_result;
  logic [4:0]       rsp_flags;
  logic [TAG_W-1:0] rsp_tag;

  modport master (
    output req_valid, req_kind, req_tag, req_result, req_flags, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_flags, rsp_tag
  );

  modport slave (
    input  req_valid, req_kind, req_tag, req_result, req_flags, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_flags, rsp_tag
  );
endinterface

// File: rtl/fp_exe_sched.sv
// In-order FP execute scheduler: dispatches ops to short path, pipelined FMA or iterative divider,
// tracks them in a circular completion queue and retires results strictly in issue order.
module fp_exe_sched #(
  parameter int XLEN    = 64,
  parameter int DEPTH   = 4,
  parameter int FMA_LAT = 3,
  parameter int TAG_W   = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            clear,
  fp_exe_sched_if.slave   bus,
  output logic            fma_issue,
  input  logic [XLEN-1:0] fma_result,
  input  logic [4:0]      fma_flags,
  output logic            div_start,
  input  logic            div_done,
  input  logic [XLEN-1:0] div_result,
  input  logic [4:0]      div_flags,
  output logic            busy
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int STG_W  = PTR_W + 1;
  localparam int PIPE_W = FMA_LAT * STG_W;
  localparam logic [PTR_W:0] PTR_ONE = 1;

  typedef enum logic {DIV_IDLE, DIV_RUN} div_state_t;

  div_state_t       div_state_q, div_state_d;
  logic [PTR_W:0]   wr_ptr_q, rd_ptr_q;
  logic [PTR_W-1:0] wr_idx, rd_idx, div_idx_q, fma_wb_idx;
  logic [DEPTH-1:0] alloc_q, done_q;
  logic [TAG_W-1:0] tag_q    [DEPTH];
  logic [XLEN-1:0]  result_q [DEPTH];
  logic [4:0]       flags_q  [DEPTH];
  logic [PIPE_W-1:0] fma_pipe_q;
  logic [STG_W-1:0] fma_out;
  logic full, empty, accept, retire, is_short, rsp_v, fma_wb, div_wb;

  assign wr_idx = wr_ptr_q[PTR_W-1:0];
  assign rd_idx = rd_ptr_q[PTR_W-1:0];
  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full   = (wr_idx == rd_idx) && (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]);

  assign bus.req_ready = !full && !clear && !(bus.req_kind == 2'd2 && div_state_q != DIV_IDLE);
  assign accept    = bus.req_valid && bus.req_ready;
  assign is_short  = (bus.req_kind == 2'd0) || (bus.req_kind == 2'd3);
  assign fma_issue = accept && (bus.req_kind == 2'd1);
  assign div_start = accept && (bus.req_kind == 2'd2);

  assign rsp_v          = alloc_q[rd_idx] && done_q[rd_idx];
  assign retire         = rsp_v && bus.rsp_ready && !clear;
  assign bus.rsp_valid  = rsp_v;
  assign bus.rsp_result = rsp_v ? result_q[rd_idx] : '0;
  assign bus.rsp_flags  = rsp_v ? flags_q[rd_idx]  : '0;
  assign bus.rsp_tag    = rsp_v ? tag_q[rd_idx]    : '0;

  // The oldest FMA stage carries {valid, slot}; its data arrives on fma_result that same cycle.
  assign fma_out    = fma_pipe_q[PIPE_W-1 -: STG_W];
  assign fma_wb     = fma_out[STG_W-1] && !clear;
  assign fma_wb_idx = fma_out[PTR_W-1:0];
  assign div_wb     = (div_state_q == DIV_RUN) && div_done && !clear;

  assign busy = !empty || (div_state_q == DIV_RUN);

  // Divider sequencing: one op in flight; a late div_done after a flush lands in IDLE and is dropped.
  always_comb begin
    div_state_d = div_state_q;
    case (div_state_q)
      DIV_IDLE: if (div_start) div_state_d = DIV_RUN;
      DIV_RUN:  if (div_done)  div_state_d = DIV_IDLE;
      default:  div_state_d = DIV_IDLE;
    endcase
    if (clear) div_state_d = DIV_IDLE;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_state_q <= DIV_IDLE;
      div_idx_q   <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fma_pipe_q  <= '0;
    end else begin
      div_state_q <= div_state_d;
      if (div_start) div_idx_q <= wr_idx;
      if (clear) begin
        wr_ptr_q   <= '0;
        rd_ptr_q   <= '0;
        fma_pipe_q <= '0;
      end else begin
        if (accept) wr_ptr_q <= wr_ptr_q + PTR_ONE;
        if (retire) rd_ptr_q <= rd_ptr_q + PTR_ONE;
        fma_pipe_q <= (fma_pipe_q << STG_W) | PIPE_W'({fma_issue, wr_idx});
      end
    end
  end

  // Allocation, the two unit writebacks and retirement always touch distinct slots, so all may land together.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      alloc_q  <= '0;
      done_q   <= '0;
      tag_q    <= '{default: '0};
      result_q <= '{default: '0};
      flags_q  <= '{default: '0};
    end else if (clear) begin
      alloc_q <= '0;
      done_q  <= '0;
    end else begin
      if (accept) begin
        alloc_q[wr_idx]  <= 1'b1;
        done_q[wr_idx]   <= is_short;
        tag_q[wr_idx]    <= bus.req_tag;
        result_q[wr_idx] <= bus.req_result;
        flags_q[wr_idx]  <= bus.req_flags;
      end
      if (fma_wb) begin
        done_q[fma_wb_idx]   <= 1'b1;
        result_q[fma_wb_idx] <= fma_result;
        flags_q[fma_wb_idx]  <= fma_flags;
      end
      if (div_wb) begin
        done_q[div_idx_q]   <= 1'b1;
        result_q[div_idx_q] <= div_result;
        flags_q[div_idx_q]  <= div_flags;
      end
      if (retire) begin
        alloc_q[rd_idx] <= 1'b0;
        done_q[rd_idx]  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fp_exe_sched.sv
// Self-checking bench for fp_exe_sched: directed ordering/flush scenarios plus a randomized run
// against an in-order expected-response queue that also plays the FMA and divider units.
module tb_fp_exe_sched;
  localparam int XLEN    = 64;
  localparam int DEPTH   = 4;
  localparam int FMA_LAT = 3;
  localparam int TAG_W   = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic clear = 1'b0;
  logic fma_issue, div_start, div_done, busy;
  logic [XLEN-1:0] fma_result, div_result;
  logic [4:0] fma_flags, div_flags;

  int n_cmp = 0;
  int n_err = 0;

  fp_exe_sched_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

  fp_exe_sched #(.XLEN(XLEN), .DEPTH(DEPTH), .FMA_LAT(FMA_LAT), .TAG_W(TAG_W)) dut (
    .clock(clock), .reset(reset), .clear(clear), .bus(bus),
    .fma_issue(fma_issue), .fma_result(fma_result), .fma_flags(fma_flags),
    .div_start(div_start), .div_done(div_done), .div_result(div_result), .div_flags(div_flags),
    .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  res;
    logic [4:0]       flg;
    int               ready_at;
  } exp_t;

  // Inputs change just after the falling edge; outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic idle();
    bus.req_valid  = 1'b0;
    bus.req_kind   = 2'd0;
    bus.req_tag    = '0;
    bus.req_result = '0;
    bus.req_flags  = '0;
    bus.rsp_ready  = 1'b0;
    clear          = 1'b0;
    div_done       = 1'b0;
    div_result     = '0;
    div_flags      = '0;
    fma_result     = '0;
    fma_flags      = '0;
  endtask

  task automatic drive_req(input logic [1:0] kind, input logic [TAG_W-1:0] tag,
                           input logic [XLEN-1:0] res, input logic [4:0] flg);
    bus.req_valid  = 1'b1;
    bus.req_kind   = kind;
    bus.req_tag    = tag;
    bus.req_result = res;
    bus.req_flags  = flg;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    drive_req(2'd1, 4'd1, '0, '0);
    tick();
    drive_req(2'd1, 4'd2, '0, '0);
    tick();
    bus.req_valid = 1'b0;
    bus.req_kind  = 2'd0;
    #1;
    n_cmp++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL busy_before_reset: got %b expected 1", busy); end
    reset = 1'b1;
    #1;
    n_cmp++;
    if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid: got %b expected 0", bus.rsp_valid); end
    n_cmp++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_cmp++;
    if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL reset_req_ready: got %b expected 1", bus.req_ready); end
    n_cmp++;
    if (bus.rsp_tag !== '0 || bus.rsp_result !== '0 || bus.rsp_flags !== '0) begin
      n_err++; $display("FAIL reset_rsp_data: got tag %0h res %0h flags %0h expected all 0",
                        bus.rsp_tag, bus.rsp_result, bus.rsp_flags);
    end
    n_cmp++;
    if (fma_issue !== 1'b0 || div_start !== 1'b0) begin
      n_err++; $display("FAIL reset_pulses: got fma_issue %b div_start %b expected 0 0", fma_issue, div_start);
    end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_short_b2b();
    do_reset();
    bus.rsp_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (c < 3) drive_req(2'd0, TAG_W'(c + 1), XLEN'(64'hA000 + c), 5'(c + 1));
      else bus.req_valid = 1'b0;
      #1;
      n_cmp++;
      if (bus.rsp_valid !== (c >= 1 && c <= 3)) begin
        n_err++; $display("FAIL short_rsp_valid c%0d: got %b expected %b", c, bus.rsp_valid, (c >= 1 && c <= 3));
      end else if (c >= 1 && c <= 3) begin
        n_cmp++;
        if (bus.rsp_tag !== TAG_W'(c) || bus.rsp_flags !== 5'(c) || bus.rsp_result !== XLEN'(64'hA000 + c - 1)) begin
          n_err++; $display("FAIL short_rsp_data c%0d: got tag %0d flags %0h res %0h expected tag %0d flags %0h res %0h",
                            c, bus.rsp_tag, bus.rsp_flags, bus.rsp_result, c, c, 64'hA000 + c - 1);
        end
      end
      tick();
    end
  endtask

  task automatic test_div_order();
    int seen [14];
    int nvalid = 0;
    logic [XLEN-1:0] div_res_seen = '0;
    do_reset();
    bus.rsp_ready = 1'b1;
    for (int c = 0; c < 14; c++) begin
      bus.req_valid = 1'b0;
      div_done = 1'b0;
      if (c == 0) drive_req(2'd2, 4'd5, 64'hDEAD, 5'h1F);
      if (c == 1) drive_req(2'd0, 4'd6, 64'h6666, 5'h02);
      if (c == 3) drive_req(2'd2, 4'd9, 64'h9999, 5'h00);
      if (c == 10) begin div_done = 1'b1; div_result = 64'h1234_5678_9ABC_DEF0; div_flags = 5'h08; end
      #1;
      if (c == 0) begin
        n_cmp++;
        if (div_start !== 1'b1) begin n_err++; $display("FAIL div_start_pulse: got %b expected 1", div_start); end
      end
      if (c == 3) begin
        n_cmp++;
        if (bus.req_ready !== 1'b0) begin n_err++; $display("FAIL div_second_ready: got %b expected 0", bus.req_ready); end
        bus.req_valid = 1'b0;
      end
      seen[c] = bus.rsp_valid ? int'(bus.rsp_tag) : -1;
      if (bus.rsp_valid) nvalid++;
      if (c == 11) div_res_seen = bus.rsp_result;
      tick();
    end
    div_done = 1'b0;
    n_cmp++;
    if (seen[11] !== 5 || seen[12] !== 6) begin
      n_err++; $display("FAIL div_order: got tags %0d,%0d at cycles 11,12 expected 5,6", seen[11], seen[12]);
    end
    n_cmp++;
    if (nvalid !== 2) begin n_err++; $display("FAIL div_rsp_count: got %0d expected 2", nvalid); end
    n_cmp++;
    if (div_res_seen !== 64'h1234_5678_9ABC_DEF0) begin
      n_err++; $display("FAIL div_result: got %0h expected 123456789abcdef0", div_res_seen);
    end
  endtask

  task automatic test_fma_order();
    int seen [8];
    int nvalid = 0;
    logic [XLEN-1:0] r4 = '0;
    logic [4:0] f4 = '0;
    do_reset();
    bus.rsp_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      bus.req_valid = 1'b0;
      fma_result = 64'hBAD0_BAD0;
      fma_flags  = 5'h1F;
      if (c == 0) drive_req(2'd1, 4'd7, 64'h0, 5'h0);
      if (c == 1) drive_req(2'd3, 4'd8, 64'h8888, 5'h04);
      if (c == FMA_LAT) begin fma_result = 64'hF00D_CAFE; fma_flags = 5'h01; end
      #1;
      if (c == 0) begin
        n_cmp++;
        if (fma_issue !== 1'b1) begin n_err++; $display("FAIL fma_issue_pulse: got %b expected 1", fma_issue); end
      end
      seen[c] = bus.rsp_valid ? int'(bus.rsp_tag) : -1;
      if (bus.rsp_valid) nvalid++;
      if (c == 4) begin r4 = bus.rsp_result; f4 = bus.rsp_flags; end
      tick();
    end
    n_cmp++;
    if (seen[4] !== 7 || seen[5] !== 8) begin
      n_err++; $display("FAIL fma_order: got tags %0d,%0d at cycles 4,5 expected 7,8", seen[4], seen[5]);
    end
    n_cmp++;
    if (nvalid !== 2) begin n_err++; $display("FAIL fma_rsp_count: got %0d expected 2", nvalid); end
    n_cmp++;
    if (r4 !== 64'hF00D_CAFE || f4 !== 5'h01) begin
      n_err++; $display("FAIL fma_result: got %0h/%0h expected f00dcafe/01", r4, f4);
    end
  endtask

  task automatic test_full();
    int nready = 0;
    do_reset();
    for (int c = 0; c < 4; c++) begin
      drive_req(2'd0, TAG_W'(c + 1), XLEN'(c), 5'(c));
      #1;
      if (bus.req_ready) nready++;
      tick();
    end
    n_cmp++;
    if (nready !== 4) begin n_err++; $display("FAIL full_fill_ready: got %0d expected 4", nready); end
    drive_req(2'd0, 4'd5, 64'h5, 5'h5);
    #1;
    n_cmp++;
    if (bus.req_ready !== 1'b0) begin n_err++; $display("FAIL full_ready: got %b expected 0", bus.req_ready); end
    tick();
    bus.rsp_ready = 1'b1;
    #1;
    n_cmp++;
    if (bus.req_ready !== 1'b0 || bus.rsp_tag !== 4'd1) begin
      n_err++; $display("FAIL full_no_bypass: got ready %b tag %0d expected 0 1", bus.req_ready, bus.rsp_tag);
    end
    tick();
    bus.rsp_ready = 1'b0;
    #1;
    n_cmp++;
    if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL full_release: got %b expected 1", bus.req_ready); end
    tick();
    bus.req_valid = 1'b0;
  endtask

  task automatic test_clear_div();
    int bad = 0;
    do_reset();
    drive_req(2'd2, 4'd3, 64'h0, 5'h0);
    tick();
    drive_req(2'd0, 4'd4, 64'h44, 5'h0);
    tick();
    drive_req(2'd2, 4'd10, 64'h0, 5'h0);
    #1;
    n_cmp++;
    if (bus.req_ready !== 1'b0 || busy !== 1'b1 || bus.rsp_valid !== 1'b0) begin
      n_err++; $display("FAIL run_state: got ready %b busy %b rsp_valid %b expected 0 1 0",
                        bus.req_ready, busy, bus.rsp_valid);
    end
    tick();
    clear = 1'b1;
    bus.rsp_ready = 1'b1;
    drive_req(2'd0, 4'd12, 64'h12, 5'h0);
    #1;
    n_cmp++;
    if (bus.req_ready !== 1'b0) begin n_err++; $display("FAIL clear_ready: got %b expected 0", bus.req_ready); end
    tick();
    clear = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_kind  = 2'd2;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      n_err++; $display("FAIL after_clear: got busy %b rsp_valid %b ready %b expected 0 0 1",
                        busy, bus.rsp_valid, bus.req_ready);
    end
    tick();
    for (int c = 0; c < 4; c++) begin
      div_done = (c == 0);
      div_result = 64'hEEEE;
      #1;
      if (c > 0 && (busy !== 1'b0 || bus.rsp_valid !== 1'b0)) bad++;
      tick();
    end
    div_done = 1'b0;
    n_cmp++;
    if (bad !== 0) begin n_err++; $display("FAIL late_div_done: got %0d bad cycles expected 0", bad); end
    drive_req(2'd0, 4'd11, 64'hB, 5'h3);
    tick();
    bus.req_valid = 1'b0;
    #1;
    n_cmp++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_tag !== 4'd11) begin
      n_err++; $display("FAIL post_clear_short: got valid %b tag %0d expected 1 11", bus.rsp_valid, bus.rsp_tag);
    end
    tick();
  endtask

  task automatic test_random();
    exp_t exp_q [$];
    exp_t e;
    logic            fv   [8];
    logic [XLEN-1:0] fres [8];
    logic [4:0]      fflg [8];
    logic [XLEN-1:0] dres = '0;
    logic [4:0]      dflg = '0;
    bit dv = 0;
    int dcyc = 0;
    int k;
    bit exp_ready, exp_rv, acc;
    do_reset();
    for (int i = 0; i < 8; i++) fv[i] = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      k = $urandom_range(0, 3);
      drive_req(k[1:0], TAG_W'($urandom), {$urandom, $urandom}, 5'($urandom_range(0, 31)));
      bus.req_valid = ($urandom_range(0, 3) != 0);
      bus.rsp_ready = ($urandom_range(0, 2) != 0);
      if (fv[cyc % 8]) begin
        fma_result = fres[cyc % 8];
        fma_flags  = fflg[cyc % 8];
        fv[cyc % 8] = 1'b0;
      end else begin
        fma_result = {$urandom, $urandom};
        fma_flags  = 5'($urandom_range(0, 31));
      end
      if (dv && cyc == dcyc) begin
        div_done = 1'b1; div_result = dres; div_flags = dflg;
      end else begin
        div_done   = !dv && ($urandom_range(0, 7) == 0);
        div_result = {$urandom, $urandom};
        div_flags  = 5'($urandom_range(0, 31));
      end
      #1;
      exp_ready = (exp_q.size() < DEPTH) && !(k == 2 && dv);
      acc = bus.req_valid && exp_ready;
      exp_rv = (exp_q.size() > 0) && (exp_q[0].ready_at <= cyc);
      n_cmp++;
      if (bus.req_ready !== exp_ready) begin
        n_err++; $display("FAIL rnd_req_ready cyc%0d: got %b expected %b", cyc, bus.req_ready, exp_ready);
      end
      n_cmp++;
      if (fma_issue !== (acc && k == 1) || div_start !== (acc && k == 2)) begin
        n_err++; $display("FAIL rnd_issue cyc%0d: got fma %b div %b expected %b %b",
                          cyc, fma_issue, div_start, (acc && k == 1), (acc && k == 2));
      end
      n_cmp++;
      if (busy !== (exp_q.size() > 0 || dv)) begin
        n_err++; $display("FAIL rnd_busy cyc%0d: got %b expected %b", cyc, busy, (exp_q.size() > 0 || dv));
      end
      n_cmp++;
      if (bus.rsp_valid !== exp_rv) begin
        n_err++; $display("FAIL rnd_rsp_valid cyc%0d: got %b expected %b", cyc, bus.rsp_valid, exp_rv);
      end else if (exp_rv) begin
        n_cmp++;
        if (bus.rsp_tag !== exp_q[0].tag || bus.rsp_result !== exp_q[0].res || bus.rsp_flags !== exp_q[0].flg) begin
          n_err++; $display("FAIL rnd_rsp_data cyc%0d: got %0h/%0h/%0h expected %0h/%0h/%0h", cyc,
                            bus.rsp_tag, bus.rsp_result, bus.rsp_flags, exp_q[0].tag, exp_q[0].res, exp_q[0].flg);
        end
      end
      if (exp_rv && bus.rsp_ready) void'(exp_q.pop_front());
      if (dv && cyc == dcyc) dv = 0;
      if (acc) begin
        e.tag = bus.req_tag;
        if (k == 1) begin
          e.res = {$urandom, $urandom};
          e.flg = 5'($urandom_range(0, 31));
          e.ready_at = cyc + FMA_LAT + 1;
          fv[(cyc + FMA_LAT) % 8]   = 1'b1;
          fres[(cyc + FMA_LAT) % 8] = e.res;
          fflg[(cyc + FMA_LAT) % 8] = e.flg;
        end else if (k == 2) begin
          e.res = {$urandom, $urandom};
          e.flg = 5'($urandom_range(0, 31));
          dv = 1;
          dcyc = cyc + $urandom_range(1, 12);
          dres = e.res;
          dflg = e.flg;
          e.ready_at = dcyc + 1;
        end else begin
          e.res = bus.req_result;
          e.flg = bus.req_flags;
          e.ready_at = cyc + 1;
        end
        exp_q.push_back(e);
      end
      tick();
    end
    idle();
  endtask

  initial begin
    idle();
    @(negedge clock);
    test_reset();
    test_short_b2b();
    test_div_order();
    test_fma_order();
    test_full();
    test_clear_div();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
